// File: rtl/seven_seg_mux.sv
// rtl/seven_seg_mux.sv - time-multiplexed seven-segment driver with per-frame input snapshot
// Scans NUM_DIGITS digits with dwell/dead time; all outputs are registered.
module seven_seg_mux #(
  parameter int NUM_DIGITS       = 2,
  parameter int REFRESH_DIV      = 24000,
  parameter int DEAD_CYCLES      = 2,
  parameter int LZS              = 0,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    frame_start
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] shadow_digits;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] eff_blank;
  logic [NUM_DIGITS-1:0] sel;
  logic                  all_zero;
  logic                  lit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0011000;
      4'ha: decode = 7'b0001000;
      4'hb: decode = 7'b0000011;
      4'hc: decode = 7'b1000110;
      4'hd: decode = 7'b0100001;
      4'he: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Walk from the most significant digit down; an explicitly blanked digit counts as zero.
  always_comb begin
    all_zero  = 1'b1;
    eff_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib[i]       = shadow_digits[4*i +: 4];
      all_zero     = all_zero & (shadow_blank[i] | (nib[i] == 4'd0));
      eff_blank[i] = shadow_blank[i] | ((LZS != 0) && (i > 0) && all_zero);
    end
    sel      = '0;
    sel[idx] = 1'b1;
    lit      = en && (cnt >= CNT_DEAD) && !eff_blank[idx];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt           <= '0;
      idx           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      shadow_blank  <= '1;
      seg           <= 7'b1111111;
      dp            <= 1'b1;
      anode         <= ANODE_OFF;
      frame_start   <= 1'b0;
    end else begin
      frame_start <= en && (cnt == CW'(1)) && (idx == '0);
      if (lit) begin
        anode <= ANODE_OFF ^ sel;
        seg   <= decode(nib[idx]);
        dp    <= ~shadow_dp[idx];
      end else begin
        anode <= ANODE_OFF;
        seg   <= 7'b1111111;
        dp    <= 1'b1;
      end
      if (en) begin
        if ((cnt == '0) && (idx == '0)) begin
          shadow_digits <= digits;
          shadow_dp     <= dp_in;
          shadow_blank  <= blank;
        end
        if (cnt == CNT_LAST) begin
          cnt <= '0;
          idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
